// File: rtl/arm_ctrl_pkg.sv
// Shared control encodings for the multicycle decoder.
// Includes FSM state names, ALUControl codes and FPControl codes.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXR     = 4'd6,
        EXI     = 4'd7,
        ALUWB   = 4'd8,
        BRANCH  = 4'd9,
        MULEX   = 4'd10,
        MULWB   = 4'd11,
        MULWBHI = 4'd12,
        FPEX    = 4'd13,
        FPWB    = 4'd14
    } state_t;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_ORR   = 4'b0011;
    localparam logic [3:0] ALU_MUL   = 4'b0100;
    localparam logic [3:0] ALU_UMULL = 4'b1000;
    localparam logic [3:0] ALU_SMULL = 4'b1100;

    localparam logic [1:0] FP_ADD16 = 2'b00;
    localparam logic [1:0] FP_ADD32 = 2'b01;
    localparam logic [1:0] FP_MUL16 = 2'b10;
    localparam logic [1:0] FP_MUL32 = 2'b11;

endpackage

// File: rtl/multicycle_decode_if.sv
// Instruction fields in, datapath controls out, plus the FP unit start/done pair.
// fp_start is a one-cycle request pulse; fp_done is a one-cycle completion pulse, honoured only in FPEX.
interface multicycle_decode_if import arm_ctrl_pkg::*; #(
    parameter int ALUW = 4
);
    logic [1:0]      Op;
    logic [5:0]      Funct;
    logic [3:0]      Rd;
    logic [3:0]      MULL_Identifier;
    logic [4:0]      FP_identifier;
    logic [3:0]      BIT_identifier;
    logic [3:0]      OP_identifier;
    logic            fp_done;

    logic            IRWrite;
    logic            AdrSrc;
    logic            NextPC;
    logic            RegW;
    logic            MemW;
    logic            WE4w;
    logic            Branch;
    logic [1:0]      ALUSrcA;
    logic [1:0]      ALUSrcB;
    logic [1:0]      ResultSrc;
    logic [1:0]      ImmSrc;
    logic [1:0]      RegSrc;
    logic [ALUW-1:0] ALUControl;
    logic [1:0]      FlagW;
    logic [1:0]      FPControl;
    logic            fp_start;
    logic            busy;
    state_t          dbg_state;

    modport master (
        output Op, Funct, Rd, MULL_Identifier, FP_identifier, BIT_identifier, OP_identifier, fp_done,
        input  IRWrite, AdrSrc, NextPC, RegW, MemW, WE4w, Branch, ALUSrcA, ALUSrcB, ResultSrc,
               ImmSrc, RegSrc, ALUControl, FlagW, FPControl, fp_start, busy, dbg_state
    );

    modport slave (
        input  Op, Funct, Rd, MULL_Identifier, FP_identifier, BIT_identifier, OP_identifier, fp_done,
        output IRWrite, AdrSrc, NextPC, RegW, MemW, WE4w, Branch, ALUSrcA, ALUSrcB, ResultSrc,
               ImmSrc, RegSrc, ALUControl, FlagW, FPControl, fp_start, busy, dbg_state
    );

endinterface

// File: rtl/alu_fp_decoder.sv
// Combinational ALUControl / FlagW / FPControl decode.
// The FSM supplies one-hot-ish state qualifiers; everything here is pure logic.
module alu_fp_decoder import arm_ctrl_pkg::*; #(
    parameter int ALUW = 4
) (
    input  logic            alu_en_i,
    input  logic            mul_en_i,
    input  logic            alu_wb_i,
    input  logic            mul_wb_i,
    input  logic            fp_en_i,
    input  logic [4:0]      funct_i,
    input  logic [3:0]      bit_id_i,
    input  logic [3:0]      op_id_i,
    output logic [ALUW-1:0] alu_control_o,
    output logic [1:0]      flag_w_o,
    output logic [1:0]      fp_control_o
);

    logic [3:0] alu_code;

    always_comb begin
        alu_code = ALU_ADD;
        if (mul_en_i) begin
            case (funct_i[3:1])
                3'b000:  alu_code = ALU_MUL;
                3'b100:  alu_code = ALU_UMULL;
                3'b110:  alu_code = ALU_SMULL;
                default: alu_code = ALU_ADD;
            endcase
        end else if (alu_en_i) begin
            case (funct_i[4:1])
                4'b0100: alu_code = ALU_ADD;
                4'b0010: alu_code = ALU_SUB;
                4'b0000: alu_code = ALU_AND;
                4'b1100: alu_code = ALU_ORR;
                default: alu_code = ALU_ADD;
            endcase
        end
    end

    // Carry/overflow flags only make sense for add/sub; multiplies never update them.
    always_comb begin
        flag_w_o = 2'b00;
        if (alu_wb_i) begin
            flag_w_o = {funct_i[0], funct_i[0] & ((alu_code == ALU_ADD) | (alu_code == ALU_SUB))};
        end else if (mul_wb_i) begin
            flag_w_o = {funct_i[0], 1'b0};
        end
    end

    always_comb begin
        fp_control_o = FP_ADD16;
        if (fp_en_i) begin
            case (bit_id_i)
                4'b0000: fp_control_o = (op_id_i == 4'b1111) ? FP_MUL32 : FP_ADD32;
                4'b1111: fp_control_o = (op_id_i == 4'b1111) ? FP_MUL16 : FP_ADD16;
                default: fp_control_o = FP_ADD16;
            endcase
        end
    end

    assign alu_control_o = ALUW'(alu_code);

endmodule

// File: rtl/multicycle_decode.sv
// Multicycle main controller: FSM, multiply cycle counter and FP start/done sequencing.
// Datapath write enables are gated off while reset is high.
module multicycle_decode import arm_ctrl_pkg::*; #(
    parameter int MUL_CYCLES = 2,
    parameter bit FP_EN      = 1'b1,
    parameter int ALUW       = 4
) (
    input  logic                clk,
    input  logic                reset,
    multicycle_decode_if.slave  bus
);

    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       fp_start_q, fp_start_d;

    logic       irwrite, adrsrc, nextpc, regw, memw, we4w, branch, busy;
    logic [1:0] alusrca, alusrcb, resultsrc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FETCH;
            cnt_q      <= 4'd0;
            fp_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fp_start_q <= fp_start_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fp_start_d = 1'b0;
        irwrite    = 1'b0;
        adrsrc     = 1'b0;
        nextpc     = 1'b0;
        regw       = 1'b0;
        memw       = 1'b0;
        we4w       = 1'b0;
        branch     = 1'b0;
        busy       = 1'b0;
        alusrca    = 2'b00;
        alusrcb    = 2'b00;
        resultsrc  = 2'b00;
        case (state_q)
            FETCH: begin
                irwrite   = 1'b1;
                nextpc    = 1'b1;
                alusrca   = 2'b01;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                state_d   = DECODE;
            end
            DECODE: begin
                alusrca   = 2'b01;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                // Op=11 is an undefined class here and simply retires without side effects.
                if (bus.Op == 2'b10) begin
                    state_d = BRANCH;
                end else if (bus.Op == 2'b01) begin
                    state_d = MEMADR;
                end else if (bus.Op == 2'b11) begin
                    state_d = FETCH;
                end else if (bus.Funct[5]) begin
                    state_d = EXI;
                end else if (FP_EN && (bus.FP_identifier == 5'b11111)) begin
                    state_d    = FPEX;
                    fp_start_d = 1'b1;
                end else if (bus.MULL_Identifier == 4'b1001) begin
                    state_d = MULEX;
                    cnt_d   = MUL_LOAD;
                end else begin
                    state_d = EXR;
                end
            end
            MEMADR:  state_d = bus.Funct[0] ? MEMRD : MEMWR;
            MEMRD:   state_d = MEMWB;
            MEMWB: begin
                regw      = 1'b1;
                resultsrc = 2'b01;
                nextpc    = (bus.Rd == 4'b1111);
                state_d   = FETCH;
            end
            MEMWR: begin
                memw    = 1'b1;
                adrsrc  = 1'b1;
                state_d = FETCH;
            end
            EXR:     state_d = ALUWB;
            EXI:     state_d = ALUWB;
            ALUWB: begin
                regw    = 1'b1;
                nextpc  = (bus.Rd == 4'b1111);
                state_d = FETCH;
            end
            BRANCH: begin
                branch  = 1'b1;
                alusrcb = 2'b01;
                state_d = FETCH;
            end
            MULEX: begin
                busy = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = bus.Funct[3] ? MULWBHI : MULWB;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            MULWB: begin
                regw    = 1'b1;
                state_d = FETCH;
            end
            MULWBHI: begin
                regw    = 1'b1;
                we4w    = 1'b1;
                state_d = FETCH;
            end
            FPEX: begin
                busy = 1'b1;
                if (bus.fp_done) begin
                    state_d = FPWB;
                end
            end
            FPWB: begin
                regw    = 1'b1;
                state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    alu_fp_decoder #(.ALUW(ALUW)) u_dec (
        .alu_en_i      ((state_q == EXR) || (state_q == EXI) || (state_q == ALUWB)),
        .mul_en_i      ((state_q == MULEX) || (state_q == MULWB) || (state_q == MULWBHI)),
        .alu_wb_i      (state_q == ALUWB),
        .mul_wb_i      ((state_q == MULWB) || (state_q == MULWBHI)),
        .fp_en_i       ((state_q == FPEX) || (state_q == FPWB)),
        .funct_i       (bus.Funct[4:0]),
        .bit_id_i      (bus.BIT_identifier),
        .op_id_i       (bus.OP_identifier),
        .alu_control_o (bus.ALUControl),
        .flag_w_o      (bus.FlagW),
        .fp_control_o  (bus.FPControl)
    );

    assign bus.IRWrite   = irwrite & ~reset;
    assign bus.NextPC    = nextpc & ~reset;
    assign bus.RegW      = regw & ~reset;
    assign bus.MemW      = memw & ~reset;
    assign bus.WE4w      = we4w & ~reset;
    assign bus.Branch    = branch & ~reset;
    assign bus.fp_start  = fp_start_q & ~reset;
    assign bus.AdrSrc    = adrsrc;
    assign bus.busy      = busy;
    assign bus.ALUSrcA   = alusrca;
    assign bus.ALUSrcB   = alusrcb;
    assign bus.ResultSrc = resultsrc;
    assign bus.ImmSrc    = bus.Op;
    assign bus.RegSrc    = {(bus.Op == 2'b01) & ~bus.Funct[0], bus.Op == 2'b10};
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_multicycle_decode.sv
// Directed and random instruction sequences for multicycle_decode, each cycle checked
// against an instruction-level model that lists the expected per-cycle control record.
module tb_multicycle_decode;
    import arm_ctrl_pkg::*;

    localparam int MC   = 3;
    localparam int ALUW = 4;

    typedef struct packed {
        state_t     st;
        logic       irw, npc, adr, regw, memw, we4w, br, busy, fps;
        logic [1:0] srca, srcb, rsrc, imm, rsel;
        logic [3:0] aluc;
        logic [1:0] flagw, fpc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    exp_t exp_q[$];
    logic done_q[$];

    logic [1:0] t_op;
    logic [5:0] t_funct;
    logic [3:0] t_rd, t_mull, t_bit, t_opid;
    logic [4:0] t_fpid;

    multicycle_decode_if #(.ALUW(ALUW)) bus ();

    multicycle_decode #(.MUL_CYCLES(MC), .FP_EN(1'b1), .ALUW(ALUW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t observe();
        exp_t o;
        o.st    = bus.dbg_state;
        o.irw   = bus.IRWrite;
        o.npc   = bus.NextPC;
        o.adr   = bus.AdrSrc;
        o.regw  = bus.RegW;
        o.memw  = bus.MemW;
        o.we4w  = bus.WE4w;
        o.br    = bus.Branch;
        o.busy  = bus.busy;
        o.fps   = bus.fp_start;
        o.srca  = bus.ALUSrcA;
        o.srcb  = bus.ALUSrcB;
        o.rsrc  = bus.ResultSrc;
        o.imm   = bus.ImmSrc;
        o.rsel  = bus.RegSrc;
        o.aluc  = bus.ALUControl;
        o.flagw = bus.FlagW;
        o.fpc   = bus.FPControl;
        return o;
    endfunction

    task automatic set_instr(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd,
                             input logic [3:0] ml, input logic [4:0] fi, input logic [3:0] bi,
                             input logic [3:0] oi);
        t_op = op; t_funct = f; t_rd = rd; t_mull = ml; t_fpid = fi; t_bit = bi; t_opid = oi;
        bus.Op = op; bus.Funct = f; bus.Rd = rd; bus.MULL_Identifier = ml;
        bus.FP_identifier = fi; bus.BIT_identifier = bi; bus.OP_identifier = oi;
    endtask

    // Model helpers: straight transcriptions of the instruction-level rules.
    function automatic exp_t base(input state_t s);
        exp_t r;
        r      = '0;
        r.st   = s;
        r.imm  = t_op;
        r.rsel = {(t_op == 2'b01) && !t_funct[0], t_op == 2'b10};
        return r;
    endfunction

    function automatic logic [3:0] alu_of(input logic [5:0] f);
        case (f[4:1])
            4'b0100: return 4'b0000;
            4'b0010: return 4'b0001;
            4'b0000: return 4'b0010;
            4'b1100: return 4'b0011;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [3:0] mul_of(input logic [5:0] f);
        case (f[3:1])
            3'b000:  return 4'b0100;
            3'b100:  return 4'b1000;
            3'b110:  return 4'b1100;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [1:0] fpc_of();
        if (t_bit == 4'b0000) return {1'b1, t_opid == 4'b1111};
        if (t_bit == 4'b1111) return {t_opid == 4'b1111, 1'b0};
        return 2'b00;
    endfunction

    task automatic push(input exp_t r, input logic done);
        exp_q.push_back(r);
        done_q.push_back(done);
    endtask

    function automatic logic noise();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push_fetch_decode();
        exp_t r;
        r = base(FETCH);  r.irw = 1; r.npc = 1; r.srca = 2'b01; r.srcb = 2'b10; r.rsrc = 2'b10;
        push(r, noise());
        r = base(DECODE); r.srca = 2'b01; r.srcb = 2'b10; r.rsrc = 2'b10;
        push(r, noise());
    endtask

    task automatic build(input int lat);
        exp_t r;
        logic [3:0] a;
        push_fetch_decode();
        if (t_op == 2'b10) begin
            r = base(BRANCH); r.br = 1; r.srcb = 2'b01; push(r, noise());
        end else if (t_op == 2'b01) begin
            push(base(MEMADR), noise());
            if (t_funct[0]) begin
                push(base(MEMRD), noise());
                r = base(MEMWB); r.regw = 1; r.rsrc = 2'b01; r.npc = (t_rd == 4'hF);
            end else begin
                r = base(MEMWR); r.memw = 1; r.adr = 1;
            end
            push(r, noise());
        end else if (t_op == 2'b11) begin
            // no execute phase: next record is the following FETCH
        end else if (t_funct[5] || (t_fpid != 5'b11111 && t_mull != 4'b1001)) begin
            a = alu_of(t_funct);
            r = base(t_funct[5] ? EXI : EXR); r.aluc = a; push(r, noise());
            r = base(ALUWB); r.regw = 1; r.npc = (t_rd == 4'hF); r.aluc = a;
            r.flagw = {t_funct[0], t_funct[0] && (a == 4'b0000 || a == 4'b0001)};
            push(r, noise());
        end else if (t_fpid == 5'b11111) begin
            for (int i = 0; i < lat; i++) begin
                r = base(FPEX); r.busy = 1; r.fps = (i == 0); r.fpc = fpc_of();
                push(r, i == lat - 1);
            end
            r = base(FPWB); r.regw = 1; r.fpc = fpc_of(); push(r, noise());
        end else begin
            a = mul_of(t_funct);
            for (int i = 0; i < MC; i++) begin
                r = base(MULEX); r.busy = 1; r.aluc = a; push(r, noise());
            end
            r = base(t_funct[3] ? MULWBHI : MULWB); r.regw = 1; r.we4w = t_funct[3];
            r.aluc = a; r.flagw = {t_funct[0], 1'b0};
            push(r, noise());
        end
    endtask

    task automatic run_queue(input string tag);
        exp_t e, o;
        int k;
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            bus.fp_done = done_q.pop_front();
            @(negedge clk);
            o = observe();
            n_cmp++;
            assert (o === e) else begin
                n_bad++;
                $error("FAIL %s cyc%0d observed=%h expected=%h", tag, k, o, e);
            end
            @(posedge clk);
            #1;
            k++;
        end
        bus.fp_done = 1'b0;
    endtask

    task automatic run_instr(input int lat, input string tag);
        build(lat);
        run_queue(tag);
    endtask

    task automatic random_instr(input int n);
        int cls, lat;
        logic [5:0] f;
        logic [3:0] rd, ml, bi, oi;
        logic [4:0] fi;
        logic [2:0] msel;
        cls = $urandom_range(0, 6);
        f   = 6'($urandom_range(0, 63));
        rd  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
        ml  = 4'($urandom_range(0, 15));
        if (ml == 4'b1001) ml = 4'b0000;
        fi  = 5'($urandom_range(0, 30));
        case ($urandom_range(0, 2))
            0:       bi = 4'b0000;
            1:       bi = 4'b1111;
            default: bi = 4'($urandom_range(1, 14));
        endcase
        oi  = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 14));
        lat = $urandom_range(1, 6);
        case ($urandom_range(0, 2))
            0:       msel = 3'b000;
            1:       msel = 3'b100;
            default: msel = 3'b110;
        endcase
        case (cls)
            0: set_instr(2'b00, {1'b0, f[4:0]}, rd, ml, fi, bi, oi);
            1: set_instr(2'b00, {1'b1, f[4:0]}, rd, ml, fi, bi, oi);
            2: set_instr(2'b01, f, rd, ml, fi, bi, oi);
            3: set_instr(2'b10, f, rd, ml, fi, bi, oi);
            4: set_instr(2'b00, {1'b0, f[4], msel, f[0]}, rd, 4'b1001, fi, bi, oi);
            5: set_instr(2'b00, {1'b0, f[4:0]}, rd, 4'($urandom_range(0, 15)), 5'b11111, bi, oi);
            default: set_instr(2'b11, f, rd, ml, fi, bi, oi);
        endcase
        run_instr(lat, $sformatf("rnd%0d", n));
    endtask

    initial begin
        exp_t r;
        reset       = 1'b1;
        bus.fp_done = 1'b0;
        set_instr(2'b00, 6'b000000, 4'd0, 4'd0, 5'd0, 4'd0, 4'd0);
        @(posedge clk);
        #1;

        // Held in reset: FETCH with every enable forced low.
        r = base(FETCH); r.srca = 2'b01; r.srcb = 2'b10; r.rsrc = 2'b10;
        push(r, 1'b0); push(r, 1'b1);
        run_queue("reset_hold");
        reset = 1'b0;

        set_instr(2'b00, 6'b001001, 4'd3, 4'd0, 5'd0, 4'd0, 4'd0);     run_instr(1, "add_s");
        set_instr(2'b00, 6'b000101, 4'hF, 4'd2, 5'd1, 4'd0, 4'd0);     run_instr(1, "sub_s_pc");
        set_instr(2'b00, 6'b111001, 4'd4, 4'd0, 5'd0, 4'd0, 4'd0);     run_instr(1, "orr_imm_s");
        set_instr(2'b01, 6'b011001, 4'hF, 4'd0, 5'd0, 4'd0, 4'd0);     run_instr(1, "ldr_pc");
        set_instr(2'b01, 6'b011001, 4'd5, 4'd0, 5'd0, 4'd0, 4'd0);     run_instr(1, "ldr");
        set_instr(2'b01, 6'b011000, 4'd5, 4'd0, 5'd0, 4'd0, 4'd0);     run_instr(1, "str");
        set_instr(2'b10, 6'b101000, 4'd0, 4'd0, 5'd0, 4'd0, 4'd0);     run_instr(1, "branch");
        set_instr(2'b00, 6'b001000, 4'd1, 4'b1001, 5'd0, 4'd0, 4'd0);  run_instr(1, "umull");
        set_instr(2'b00, 6'b001101, 4'd1, 4'b1001, 5'd0, 4'd0, 4'd0);  run_instr(1, "smulls");
        set_instr(2'b00, 6'b000001, 4'd1, 4'b1001, 5'd0, 4'd0, 4'd0);  run_instr(1, "mul_s");
        set_instr(2'b00, 6'b000000, 4'd2, 4'd0, 5'b11111, 4'b0000, 4'b1111); run_instr(5, "fp_mul32");
        set_instr(2'b00, 6'b000000, 4'd2, 4'd0, 5'b11111, 4'b1111, 4'b0011); run_instr(1, "fp_add16_fast");
        set_instr(2'b11, 6'b010101, 4'hF, 4'd0, 5'd0, 4'd0, 4'd0);     run_instr(1, "op11");

        // Reset in the second MULEX cycle: no write-back may follow.
        set_instr(2'b00, 6'b001000, 4'd1, 4'b1001, 5'd0, 4'd0, 4'd0);
        push_fetch_decode();
        r = base(MULEX); r.busy = 1; r.aluc = 4'b1000; push(r, 1'b0);
        run_queue("rst_mul_pre");
        reset = 1'b1;
        push(r, 1'b0);
        run_queue("rst_mul_hold");
        reset = 1'b0;
        set_instr(2'b00, 6'b001001, 4'd3, 4'd0, 5'd0, 4'd0, 4'd0);     run_instr(1, "rst_mul_after");

        // Reset in the first FPEX cycle: fp_start must be suppressed.
        set_instr(2'b00, 6'b000000, 4'd2, 4'd0, 5'b11111, 4'b0000, 4'b0001);
        push_fetch_decode();
        run_queue("rst_fp_pre");
        reset = 1'b1;
        r = base(FPEX); r.busy = 1; r.fpc = 2'b01; push(r, 1'b1);
        run_queue("rst_fp_hold");
        reset = 1'b0;
        set_instr(2'b01, 6'b011001, 4'd6, 4'd0, 5'd0, 4'd0, 4'd0);     run_instr(1, "rst_fp_after");

        for (int n = 0; n < 60; n++) begin
            random_instr(n);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_decode.md
MULTICYCLE_DECODE -- requirements
Module: multicycle_decode

Interface
REQ-001 Parameter MUL_CYCLES, default 2, number of execute cycles a MUL/UMULL/SMULL occupies (1..15).
REQ-002 Parameter FP_EN, default 1, 1 = floating-point instruction class decoded, 0 = FP encodings decode as data-processing.
REQ-003 Parameter ALUW, default 4, width of ALUControl.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 Op  input  2  instruction class; Funct  input  6  instr[25:20]; Rd  input  4  destination register.
REQ-007 MULL_Identifier  input  4  instr[7:4]; FP_identifier  input  5; BIT_identifier  input  4; OP_identifier  input  4.
REQ-008 fp_done  input  1  FP unit result valid, single-cycle pulse.
REQ-009 IRWrite, AdrSrc, NextPC, RegW, MemW, WE4w, Branch  output  1 each  datapath enables.
REQ-010 ALUSrcA  output  2; ALUSrcB  output  2; ResultSrc  output  2; ImmSrc  output  2; RegSrc  output  2.
REQ-011 ALUControl  output  ALUW; FlagW  output  2; FPControl  output  2; fp_start  output  1; busy  output  1.

Function
REQ-012 Main FSM states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXR, EXI, ALUWB, BRANCH, MULEX, MULWB, MULWBHI, FPEX, FPWB.
REQ-013 FETCH: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10; always -> DECODE.
REQ-014 DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10; next by priority: Op=10 -> BRANCH; Op=01 -> MEMADR; Op=00 & Funct[5] -> EXI; FP_EN & FP_identifier=11111 -> FPEX; MULL_Identifier=1001 -> MULEX; else EXR.
REQ-015 MEMADR -> MEMRD if Funct[0]=1, else MEMWR; MEMRD -> MEMWB; MEMWB (RegW=1, ResultSrc=01) -> FETCH; MEMWR (MemW=1, AdrSrc=1) -> FETCH.
REQ-016 EXR/EXI -> ALUWB; ALUWB RegW=1, ResultSrc=00 -> FETCH; BRANCH Branch=1, ALUSrcB=01 -> FETCH.
REQ-017 NextPC additionally asserted in ALUWB and MEMWB when Rd=1111.
REQ-018 MULEX holds a 4-bit down-counter loaded with MUL_CYCLES-1 on DECODE->MULEX; exits when counter=0: -> MULWBHI if Funct[3]=1 (UMULL/SMULL), else MULWB.
REQ-019 MULWBHI asserts RegW=1 and WE4w=1 in the same cycle (RdLo and RdHi both written) -> FETCH; MULWB asserts RegW only -> FETCH.
REQ-020 FPEX: fp_start=1 in the first FPEX cycle only; stay until fp_done=1, then -> FPWB; FPWB RegW=1 -> FETCH.
REQ-021 fp_done outside FPEX is ignored; fp_done in the same cycle as fp_start is accepted (exit after one cycle).
REQ-022 ALUControl (EXR, EXI, ALUWB, MULEX, MULWB, MULWBHI): Funct[4:1] 0100->0000, 0010->0001, 0000->0010, 1100->0011, other->0000; MUL Funct[3:1] 000->0100, 100->1000, 110->1100; all other states ALUControl=0000.
REQ-023 FlagW valid only in ALUWB and MULWB/MULWBHI: FlagW[1]=Funct[0]; FlagW[0]=Funct[0] & (ALUControl is 0000 or 0001) in ALUWB, 0 for multiplies; 00 elsewhere.
REQ-024 FPControl: BIT_identifier 0000 -> {1, OP_identifier==1111 ? 1 : 0}: 01 add32, 11 mul32; 1111 -> 00 add16, 10 mul16; other -> 00; driven only in FPEX/FPWB, 00 elsewhere.
REQ-025 ImmSrc=Op, RegSrc = {Op==01 & ~Funct[0], Op==10} combinationally from inputs in every state.
REQ-026 busy=1 in MULEX and FPEX.
REQ-027 Op=11 in DECODE -> FETCH with no write enables asserted.

Reset
REQ-028 reset=1 at a clock edge: state -> FETCH, counter -> 0, fp_start -> 0, regardless of current state (including mid-MULEX/FPEX).
REQ-029 While reset is high, RegW, MemW, WE4w, IRWrite, NextPC, Branch and fp_start are forced 0.

Structure
REQ-030 State encoding, ALUControl and FPControl constants live in shared package arm_ctrl_pkg.
REQ-031 Combinational ALUControl/FlagW/FPControl decoding goes in sub-module alu_fp_decoder; FSM and counter stay in multicycle_decode.

Verification
REQ-032 ADD, S=1 (Op=00, Funct=001001) -> FETCH, DECODE, EXR, ALUWB; ALUWB: RegW=1, ALUControl=0000, FlagW=11.
REQ-033 LDR (Op=01, Funct=011001) -> MEMADR, MEMRD, MEMWB; RegW=1 only in MEMWB; Rd=1111 adds NextPC=1.
REQ-034 UMULL, MUL_CYCLES=3 (MULL_Identifier=1001, Funct=001000) -> 3 MULEX cycles, then MULWBHI with RegW=WE4w=1, ALUControl=1000.
REQ-035 FP mul32 (FP_identifier=11111, BIT=0000, OP=1111), fp_done after 5 cycles -> fp_start one cycle, FPControl=11, FPWB RegW=1.
REQ-036 reset asserted on the 2nd MULEX cycle -> next state FETCH, RegW and WE4w never asserted.
